pairwise_match_trigger: RTL and testbench

- Parametrised, pipelined successor to the 5-input replication/XOR pairwise comparator.
- Compares N channels of W bits each for pairwise equality, giving an N×N match matrix.
- Reduces the matrix to a match count and runs a trigger FSM with re-arm and holdoff.
- Keeps a sticky per-pair history. Sits between input samplers and the capture/debug logic that consumes trigger pulses.

---
 rtl/pairwise_match_pkg.sv | 27 ++
 rtl/pairwise_eq_matrix.sv | 16 +
 rtl/pairwise_match_trigger.sv | 113 +++++++++++
 tb/tb_pairwise_match_trigger.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pairwise_match_pkg.sv
// rtl/pairwise_match_pkg.sv - shared types and helpers for the pairwise match trigger
package pairwise_match_pkg;

    typedef enum logic [1:0] {
        ARMED    = 2'd0,
        FIRE     = 2'd1,
        HOLDOFF  = 2'd2,
        WAIT_LOW = 2'd3
    } trig_state_t;

    // Widest matrix supported: 16 channels -> 256 pair bits
    localparam int POP_MAX_W = 256;

    function automatic int match_cnt_width(input int n);
        return $clog2(n * n + 1);
    endfunction

    function automatic logic [8:0] popcount(input logic [POP_MAX_W-1:0] v);
        logic [8:0] c;
        c = '0;
        for (int i = 0; i < POP_MAX_W; i++) begin
            c = c + {8'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/pairwise_eq_matrix.sv
// rtl/pairwise_eq_matrix.sv - combinational NxN channel equality matrix
module pairwise_eq_matrix #(
    parameter int N = 5,
    parameter int W = 1
) (
    input  logic [N*W-1:0] data,
    output logic [N*N-1:0] match
);

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            assign match[i*N+j] = (data[i*W +: W] == data[j*W +: W]);
        end
    end

endmodule

// File: rtl/pairwise_match_trigger.sv
// rtl/pairwise_match_trigger.sv - pipelined pairwise comparator with trigger FSM and sticky history
module pairwise_match_trigger
    import pairwise_match_pkg::*;
#(
    parameter int N      = 5,
    parameter int W      = 1,
    parameter int THRESH = N * N,
    parameter int HOLD   = 4,
    parameter int CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [N*W-1:0]             in_data,
    input  logic                       clear_sticky,
    output logic                       out_valid,
    output logic [N*N-1:0]             match,
    output logic [$clog2(N*N+1)-1:0]   match_cnt,
    output logic [N*N-1:0]             sticky,
    output logic                       trigger,
    output logic [CNT_W-1:0]           trig_count,
    output logic                       armed
);

    localparam int CW = match_cnt_width(N);
    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'((HOLD > 0) ? HOLD - 1 : 0);
    localparam logic [CW-1:0] THRESH_C  = CW'(THRESH);

    logic [N*W-1:0]       d1;
    logic                 v1;
    logic [N*N-1:0]       eq;
    logic [POP_MAX_W-1:0] eq_ext;
    logic [CW-1:0]        eq_cnt;
    logic                 cond;
    logic [HW-1:0]        hold_cnt;
    trig_state_t          state;
    trig_state_t          state_next;

    pairwise_eq_matrix #(.N(N), .W(W)) u_eq (
        .data  (d1),
        .match (eq)
    );

    assign eq_ext = POP_MAX_W'(eq);
    assign eq_cnt = CW'(popcount(eq_ext));

    always_ff @(posedge clk) begin
        if (rst) begin
            d1 <= '0;
            v1 <= 1'b0;
        end else begin
            v1 <= in_valid;
            if (in_valid) begin
                d1 <= in_data;
            end
        end
    end

    // Stage 2 holds its last result across bubbles
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            match     <= '0;
            match_cnt <= '0;
        end else begin
            out_valid <= v1;
            if (v1) begin
                match     <= eq;
                match_cnt <= eq_cnt;
            end
        end
    end

    // A clear in the same cycle as a valid result keeps the new bits
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky <= '0;
        end else begin
            sticky <= (clear_sticky ? '0 : sticky) | (out_valid ? match : '0);
        end
    end

    assign cond = out_valid && (match_cnt >= THRESH_C);

    always_comb begin
        state_next = state;
        trigger    = (state == FIRE);
        armed      = (state == ARMED);
        case (state)
            ARMED:    if (cond) state_next = FIRE;
            FIRE:     state_next = (HOLD > 0) ? HOLDOFF : WAIT_LOW;
            HOLDOFF:  if (hold_cnt == HOLD_LAST) state_next = WAIT_LOW;
            WAIT_LOW: if (out_valid && (match_cnt < THRESH_C)) state_next = ARMED;
            default:  state_next = ARMED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARMED;
            hold_cnt   <= '0;
            trig_count <= '0;
        end else begin
            state    <= state_next;
            hold_cnt <= (state == HOLDOFF) ? hold_cnt + 1'b1 : '0;
            if ((state_next == FIRE) && (trig_count != '1)) begin
                trig_count <= trig_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pairwise_match_trigger.sv
// tb/tb_pairwise_match_trigger.sv - self-checking bench for pairwise_match_trigger
module tb_pairwise_match_trigger;

    localparam int N  = 5;
    localparam int W  = 1;
    localparam int NN = N * N;
    localparam int NI = 3;
    localparam int TH[NI]    = '{25, 5, 25};
    localparam int HOLDP[NI] = '{4, 0, 0};
    localparam int CMAX[NI]  = '{65535, 65535, 3};

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic [N*W-1:0] in_data;
    logic           clear_sticky;

    logic           ov[NI];
    logic [NN-1:0]  mt[NI];
    logic [4:0]     mc[NI];
    logic [NN-1:0]  st[NI];
    logic           tr[NI];
    logic [15:0]    tc[NI];
    logic           ar[NI];
    logic [1:0]     tc_c;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pairwise_match_trigger #(.N(N), .W(W), .THRESH(25), .HOLD(4), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clear_sticky(clear_sticky),
        .out_valid(ov[0]), .match(mt[0]), .match_cnt(mc[0]), .sticky(st[0]),
        .trigger(tr[0]), .trig_count(tc[0]), .armed(ar[0]));

    pairwise_match_trigger #(.N(N), .W(W), .THRESH(5), .HOLD(0), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clear_sticky(clear_sticky),
        .out_valid(ov[1]), .match(mt[1]), .match_cnt(mc[1]), .sticky(st[1]),
        .trigger(tr[1]), .trig_count(tc[1]), .armed(ar[1]));

    pairwise_match_trigger #(.N(N), .W(W), .THRESH(25), .HOLD(0), .CNT_W(2)) dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clear_sticky(clear_sticky),
        .out_valid(ov[2]), .match(mt[2]), .match_cnt(mc[2]), .sticky(st[2]),
        .trigger(tr[2]), .trig_count(tc_c), .armed(ar[2]));

    assign tc[2] = {14'd0, tc_c};

    task automatic chk(input string nm, input int k, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %0h want %0h", nm, k, got, exp);
        end
    endtask

    function automatic logic [NN-1:0] eqmat(input logic [N*W-1:0] d);
        logic [NN-1:0] r;
        int ci, cj;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                ci = int'((d >> (i * W)) & ((1 << W) - 1));
                cj = int'((d >> (j * W)) & ((1 << W) - 1));
                r[i*N+j] = (ci == cj);
            end
        end
        return r;
    endfunction

    function automatic int ones(input logic [NN-1:0] m);
        int c = 0;
        for (int i = 0; i < NN; i++) c += int'(m[i]);
        return c;
    endfunction

    // Behavioural model: outputs after edge e come from the sample at edge e-1
    int             cyc = 0;
    bit             s_v[1024];
    logic [N*W-1:0] s_d[1024];
    bit             s_r[1024];
    bit             m_ov = 0;
    logic [NN-1:0]  m_match = '0;
    logic [NN-1:0]  m_sticky = '0;
    int             m_cnt = 0;
    bit             m_trig[NI];
    bit             m_armed[NI];
    int             m_tc[NI];
    int             low_from[NI];

    always @(posedge clk) begin : model
        bit c;
        int p;
        cyc = cyc + 1;
        s_v[cyc % 1024] = in_valid;
        s_d[cyc % 1024] = in_data;
        s_r[cyc % 1024] = rst;
        for (int k = 0; k < NI; k++) begin
            if (rst) begin
                m_trig[k] = 0; m_armed[k] = 1; m_tc[k] = 0; low_from[k] = 0;
            end else begin
                c = m_ov && (m_cnt >= TH[k]);
                m_trig[k] = 0;
                if (m_armed[k] && c) begin
                    m_trig[k] = 1;
                    m_armed[k] = 0;
                    if (m_tc[k] < CMAX[k]) m_tc[k]++;
                    low_from[k] = cyc + HOLDP[k] + 1;
                end else if (!m_armed[k] && (cyc - 1 >= low_from[k]) && m_ov && (m_cnt < TH[k])) begin
                    m_armed[k] = 1;
                end
            end
        end
        if (rst) m_sticky = '0;
        else     m_sticky = (clear_sticky ? '0 : m_sticky) | (m_ov ? m_match : '0);
        p = (cyc - 1) % 1024;
        if (rst) begin
            m_ov = 0; m_match = '0; m_cnt = 0;
        end else begin
            m_ov = s_v[p] && !s_r[p];
            if (m_ov) begin
                m_match = eqmat(s_d[p]);
                m_cnt   = ones(m_match);
            end
        end
    end

    always @(negedge clk) begin
        if (cyc >= 1) begin
            for (int k = 0; k < NI; k++) begin
                chk("out_valid", k, 64'(ov[k]), 64'(m_ov));
                chk("match", k, 64'(mt[k]), 64'(m_match));
                chk("match_cnt", k, 64'(mc[k]), 64'(m_cnt));
                chk("sticky", k, 64'(st[k]), 64'(m_sticky));
                chk("trigger", k, 64'(tr[k]), 64'(m_trig[k]));
                chk("trig_count", k, 64'(tc[k]), 64'(m_tc[k]));
                chk("armed", k, 64'(ar[k]), 64'(m_armed[k]));
            end
        end
    end

    task automatic step(input logic v, input logic [N*W-1:0] d);
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ntrig;
        int armed_seen;
        logic [7:0] pat;
        logic [8:0] obs;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; clear_sticky = 1'b0;
        step(0, 0); step(0, 0);
        chk("rst_out_valid", 0, 64'(ov[0]), 0);
        chk("rst_match", 0, 64'(mt[0]), 0);
        chk("rst_cnt", 0, 64'(mc[0]), 0);
        chk("rst_armed", 0, 64'(ar[0]), 1);
        chk("rst_tc", 0, 64'(tc[0]), 0);
        rst = 1'b0;

        step(1, 5'b00000);
        step(0, 0);
        chk("s1_valid", 0, 64'(ov[0]), 1);
        chk("s1_match", 0, 64'(mt[0]), 64'h1ffffff);
        chk("s1_cnt", 0, 64'(mc[0]), 25);
        chk("s1_pre_trig", 0, 64'(tr[0]), 0);
        step(0, 0);
        chk("s1_trig", 0, 64'(tr[0]), 1);
        chk("s1_tc", 0, 64'(tc[0]), 1);
        chk("s1_trig_b", 1, 64'(tr[1]), 1);
        step(0, 0);
        chk("s1_pulse_end", 0, 64'(tr[0]), 0);
        clear_sticky = 1'b1; step(0, 0); clear_sticky = 1'b0;
        chk("s1_sticky_clr", 0, 64'(st[0]), 0);

        step(1, 5'b00001);
        step(0, 0);
        chk("s2_cnt", 0, 64'(mc[0]), 17);
        chk("s2_row0", 0, 64'(mt[0][4:0]), 5'b00001);
        step(1, 5'b10011);
        step(0, 0);
        chk("s3_cnt", 0, 64'(mc[0]), 13);
        step(0, 0);
        chk("s3_sticky_pop", 0, 64'($countones(st[0])), 21);
        step(1, 5'b00011);
        step(0, 0);
        clear_sticky = 1'b1; step(0, 0); clear_sticky = 1'b0;
        chk("s3_clr_pop", 0, 64'($countones(st[0])), 13);
        chk("s3_clr_row0", 0, 64'(st[0][4:0]), 5'b00011);
        chk("s5_b_tc", 1, 64'(tc[1]), 1);
        chk("s5_b_armed", 1, 64'(ar[1]), 0);

        rst = 1'b1; step(0, 0); rst = 1'b0;
        chk("s4_armed_init", 0, 64'(ar[0]), 1);
        ntrig = 0; armed_seen = 0;
        for (int i = 0; i < 12; i++) begin
            step((i < 10) ? 1'b1 : 1'b0, 5'b00000);
            ntrig += int'(tr[0]);
            if (ntrig > 0) armed_seen |= int'(ar[0]);
        end
        chk("s4_one_trig", 0, 64'(ntrig), 1);
        chk("s4_armed_low", 0, 64'(armed_seen), 0);
        step(1, 5'b00001);
        step(0, 0);
        chk("s4_not_yet", 0, 64'(ar[0]), 0);
        step(0, 0);
        chk("s4_rearmed", 0, 64'(ar[0]), 1);
        step(1, 5'b11111);
        step(0, 0);
        step(0, 0);
        chk("s4_trig2", 0, 64'(tr[0]), 1);
        chk("s4_tc2", 0, 64'(tc[0]), 2);

        step(0, 0); step(0, 0);
        step(1, 5'b00000);
        rst = 1'b1; step(0, 0); rst = 1'b0;
        chk("s6_rst_valid", 0, 64'(ov[0]), 0);
        chk("s6_rst_armed", 0, 64'(ar[0]), 1);
        ntrig = 0;
        for (int i = 0; i < 4; i++) begin
            step(0, 0);
            ntrig += int'(tr[0]) + int'(tr[1]) + int'(tr[2]);
        end
        chk("s6_no_trig", 0, 64'(ntrig), 0);
        chk("s6_sticky", 0, 64'(st[0]), 0);

        pat = 8'b0100_1101;
        obs = '0;
        for (int i = 0; i < 9; i++) begin
            step((i < 8) ? pat[i] : 1'b0, 5'(i * 7));
            obs[i] = ov[0];
        end
        chk("s6_gaps", 0, 64'(obs), 9'b010011010);

        for (int i = 0; i < 10; i++) begin
            step(1, 5'b00000);
            step(1, 5'b00001);
        end
        step(0, 0); step(0, 0); step(0, 0);
        chk("s5_c_sat", 2, 64'(tc[2]), 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
